step_sequencer: RTL and testbench
=================================

# step_sequencer

Tempo-driven note sequencer at the head of the synth voice chain. Each step tick reads a programmable step table and drives `freq`, the phase increment for the sine generator, and `gate`, the trigger for the ADSR envelope generator. It runs in the sample-clock domain (DACLRC, 48 kHz), the same domain as its consumers. Steps can be muted, the loop length can be changed, and back-to-back notes force a one-cycle gate gap so the envelope always retriggers.

## Interface
- STEPS, 8: table depth; power of two, 2..16; AW = log2(STEPS)
- PHASE_SIZE, 16: width of `freq` / table entries
- GATE_CYCLES, 12000: clk cycles `gate` stays high per active step (250 ms at 48 kHz); must be >= 1
- clk  in  1  sample clock (DACLRC); all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  high = sequencing; low = stop, silence and rewind
- tick  in  1  step pulse from the tempo block (quarter); asynchronous to clk, high for >= 2 clk cycles
- length  in  AW  index of last step in the loop (0..STEPS-1)
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table entry to write
- wr_freq  in  PHASE_SIZE  phase increment for that entry
- wr_active  in  1  1 = note, 0 = rest
- freq  out  PHASE_SIZE  phase increment of current step; held between steps
- gate  out  1  envelope gate
- step  out  AW  index of step currently playing
- step_strobe  out  1  one-cycle pulse when a new step loads

## Operation
- Reset (rst low, async): freq=0, gate=0, step=0, step_strobe=0, ptr=0, state IDLE, all table freq=0, all active=1, synchronizer flops=0.
- tick passes through a 2-flop synchronizer, then a rising-edge detector. This produces `adv`, one cycle wide.
- ptr = next step to play.
- FSM states: IDLE, GATE_ON, GATE_OFF, RETRIG.
- LOAD action, performed in IDLE/GATE_OFF on adv with run=1, or in RETRIG unconditionally:
  - freq <= table_freq[ptr]; step <= ptr; step_strobe <= 1
  - ptr <= (ptr >= length) ? 0 : ptr+1
  - if active[ptr]: gate <= 1, cnt <= GATE_CYCLES-1, go GATE_ON
  - else: gate stays 0, go GATE_OFF
- GATE_ON: when cnt == 0, gate <= 0 and go GATE_OFF; otherwise cnt decrements. On adv, gate <= 0 and go RETRIG; adv has priority over expiry.
- GATE_OFF: wait for adv.
- run low (synchronous, highest priority after reset): gate <= 0, ptr <= 0, go IDLE. freq and step hold their values. adv is ignored while run is low.
- The table write port is always active. A write and a LOAD to the same entry in one cycle: LOAD reads the old value (read-before-write).
- Reducing `length` below ptr causes a wrap to 0 at the next LOAD.

## Timing
- tick first sampled high at edge N: adv is high during cycle N+2.
- LOAD from IDLE/GATE_OFF: outputs update at edge N+3.
- Retrigger from GATE_ON: gate falls at N+3 and stays low for exactly one cycle. LOAD happens at N+4.
- Active step: gate is high for exactly GATE_CYCLES cycles if no adv arrives.
- step_strobe is high for exactly one cycle per LOAD, coincident with the freq/step update.
- run falling: gate is low at the next edge.
- Reset mid-note: all outputs return to reset values immediately (async).

## Test plan
- Reset, write entries 0..3 with freq 0x0100/0x0200/0x0300/0x0400 (all active), length=3, run=1, tick every 20000 cycles:
  - freq cycles 0x0100,0x0200,0x0300,0x0400,0x0100
  - step 0,1,2,3,0
  - gate high 12000 cycles per step
  - update 3 cycles after each tick edge
- Set entry 1 active=0 and repeat:
  - step 1 loads freq 0x0200 with step_strobe
  - gate stays low for that whole step
- Set GATE_CYCLES=12000, tick every 6000 cycles:
  - gate drops for exactly one cycle before each new step
  - no step is skipped
- With ptr=3, change length to 1:
  - next LOAD plays step 3
  - following LOADs play 0, 1, 0
- Drop run mid-note:
  - gate is 0 next cycle
  - ticks are ignored
  - raise run and tick: step 0 plays
- Write entry 2 in the same cycle it loads:
  - old value is output
  - new value is played on the next lap

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: tempo-driven note sequencer. It reads a programmable step
// table on each synchronized tick and drives the oscillator phase increment
// (freq) and the envelope gate.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped or rewound; waits for a tick to load a step
// GATE_ON  | note playing; gate high while the duration timer runs
// GATE_OFF | note finished or rest step; waits for the next tick
// RETRIG   | tick arrived during a note; one low gate cycle, then load
module step_sequencer #(
    parameter int STEPS       = 8,
    parameter int PHASE_SIZE  = 16,
    parameter int GATE_CYCLES = 12000,
    localparam int AW         = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  tick,
    input  logic [AW-1:0]         length,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PHASE_SIZE-1:0] wr_freq,
    input  logic                  wr_active,
    output logic [PHASE_SIZE-1:0] freq,
    output logic                  gate,
    output logic [AW-1:0]         step,
    output logic                  step_strobe
);

    // Sized so GATE_CYCLES-1 always fits, including GATE_CYCLES == 1.
    localparam int CW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_ON  = 2'd1,
        GATE_OFF = 2'd2,
        RETRIG   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  tick_s1;
    logic                  tick_s2;
    logic                  tick_s3;
    logic                  adv;
    logic [AW-1:0]         ptr;
    logic [CW-1:0]         cnt;
    logic                  do_load;
    logic                  gate_nxt;
    logic [PHASE_SIZE-1:0] tbl_freq [STEPS];
    logic [STEPS-1:0]      tbl_active;

    // Synchronize tick, then register a one-cycle pulse on its rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_s3 <= 1'b0;
            adv     <= 1'b0;
        end else begin
            tick_s1 <= tick;
            tick_s2 <= tick_s1;
            tick_s3 <= tick_s2;
            adv     <= tick_s2 & ~tick_s3;
        end
    end

    // Step table; the write port is always open and a same-cycle LOAD sees the old entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_freq[i] <= '0;
            end
            tbl_active <= '1;
        end else if (wr_en) begin
            tbl_freq[wr_addr]   <= wr_freq;
            tbl_active[wr_addr] <= wr_active;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; run low overrides everything and rewinds to IDLE.
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                GATE_ON: begin
                    if (adv) begin
                        state_nxt = RETRIG;
                    end else if (cnt == '0) begin
                        state_nxt = GATE_OFF;
                    end
                end
                default: ;
            endcase
            if (do_load) begin
                state_nxt = tbl_active[ptr] ? GATE_ON : GATE_OFF;
            end
        end
    end

    // Output decode: when to load a step and what the gate does next.
    always_comb begin
        do_load  = 1'b0;
        gate_nxt = gate;
        if (!run) begin
            gate_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, GATE_OFF: do_load = adv;
                GATE_ON: begin
                    if (adv || cnt == '0) begin
                        gate_nxt = 1'b0;
                    end
                end
                RETRIG:  do_load = 1'b1;
                default: ;
            endcase
            if (do_load) begin
                gate_nxt = tbl_active[ptr];
            end
        end
    end

    // Registered outputs, step pointer and gate duration down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq        <= '0;
            gate        <= 1'b0;
            step        <= '0;
            step_strobe <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            gate        <= gate_nxt;
            step_strobe <= do_load;
            if (!run) begin
                ptr <= '0;
            end else if (do_load) begin
                ptr <= (ptr >= length) ? '0 : ptr + AW'(1);
            end
            if (do_load) begin
                freq <= tbl_freq[ptr];
                step <= ptr;
                cnt  <= CW'(GATE_CYCLES - 1);
            end else if (state == GATE_ON && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a time-based reference model.
module tb_step_sequencer;

    localparam int STEPS = 8;
    localparam int PW    = 16;
    localparam int GC    = 40;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          tick;
    logic [AW-1:0] length;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_freq;
    logic          wr_active;
    logic [PW-1:0] freq;
    logic          gate;
    logic [AW-1:0] step;
    logic          step_strobe;

    int vectors     = 0;
    int miscompares = 0;

    step_sequencer #(.STEPS(STEPS), .PHASE_SIZE(PW), .GATE_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .run(run), .tick(tick), .length(length),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_active(wr_active),
        .freq(freq), .gate(gate), .step(step), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A note is described by when it started and when it must end; a
    // tick counts as seen three edges after it is first sampled high.
    int unsigned m_tbl [STEPS];
    bit          m_act [STEPS];
    int          m_ptr, m_freq, m_step;
    bit          m_gate, m_strobe, m_retrig;
    longint      cyc = 0;
    longint      m_off_at;
    bit          hist [5];

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_tbl[i] = 0;
            m_act[i] = 1'b1;
        end
        for (int i = 0; i < 5; i++) hist[i] = 1'b0;
        m_ptr = 0; m_freq = 0; m_step = 0;
        m_gate = 1'b0; m_strobe = 1'b0; m_retrig = 1'b0; m_off_at = 0;
    endtask

    task automatic model_load(input int len);
        m_freq   = m_tbl[m_ptr];
        m_step   = m_ptr;
        m_strobe = 1'b1;
        m_gate   = m_act[m_ptr];
        m_off_at = cyc + GC;
        m_retrig = 1'b0;
        m_ptr    = (m_ptr >= len) ? 0 : m_ptr + 1;
    endtask

    // Advance the model at every edge, then compare just after it.
    always @(posedge clk) begin
        bit adv_seen;
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0]  = tick;
            adv_seen = hist[3] && !hist[4];
            m_strobe = 1'b0;
            if (!run) begin
                m_gate = 1'b0; m_ptr = 0; m_retrig = 1'b0;
            end else if (m_retrig || (adv_seen && !m_gate)) begin
                model_load(int'(length));
            end else if (adv_seen && m_gate) begin
                m_gate = 1'b0; m_retrig = 1'b1;
            end else if (m_gate && cyc == m_off_at) begin
                m_gate = 1'b0;
            end
            if (wr_en) begin
                m_tbl[wr_addr] = wr_freq;
                m_act[wr_addr] = wr_active;
            end
        end
        #1;
        chk("mon_freq",   32'(freq),        32'(m_freq));
        chk("mon_step",   32'(step),        32'(m_step));
        chk("mon_gate",   32'(gate),        32'(m_gate));
        chk("mon_strobe", 32'(step_strobe), 32'(m_strobe));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_entry(input int a, input int f, input bit act);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_freq = PW'(f); wr_active = act;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulse tick and return at the first edge showing step_strobe (bounded).
    task automatic do_step(input string name);
        bit seen = 1'b0;
        @(negedge clk); tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (step_strobe) seen = 1'b1;
        end
        chk({name, "_strobe_seen"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        bit            do_wr;
        int            wa;
        int            wf;
        bit            wact;
        logic [AW-1:0] len;
        bit            retrig;
        int            gap;
        logic [PW-1:0] efreq;
        logic [AW-1:0] estep;
        bit            egate;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mkv(bit dw, int wa, int wf, bit wact, int len, bit rt,
                                 int gap, int ef, int es, bit eg);
        vec_t v;
        v.do_wr = dw; v.wa = wa; v.wf = wf; v.wact = wact;
        v.len = AW'(len); v.retrig = rt; v.gap = gap;
        v.efreq = PW'(ef); v.estep = AW'(es); v.egate = eg;
        return v;
    endfunction

    initial begin
        int cnt_hi;
        int strobes;
        rst = 1'b0; run = 1'b0; tick = 1'b0; length = '0;
        wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_active = 1'b0;

        //          wr  a  freq    act len rt gap  efreq   es eg
        vt[0]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0100, 0, 1);
        vt[1]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0200, 1, 1);
        vt[2]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0300, 2, 1);
        vt[3]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0400, 3, 1);
        vt[4]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0100, 0, 1);
        vt[5]  = mkv(1, 1, 'h0200, 0,  3,  0, 60, 16'h0200, 1, 0);
        vt[6]  = mkv(0, 0, 0,      0,  3,  0, 60, 16'h0300, 2, 1);
        vt[7]  = mkv(1, 1, 'h0200, 1,  3,  0, 10, 16'h0400, 3, 1);
        vt[8]  = mkv(0, 0, 0,      0,  3,  1, 10, 16'h0100, 0, 1);
        vt[9]  = mkv(0, 0, 0,      0,  3,  1, 10, 16'h0200, 1, 1);
        vt[10] = mkv(0, 0, 0,      0,  3,  1, 60, 16'h0300, 2, 1);
        vt[11] = mkv(0, 0, 0,      0,  1,  0, 60, 16'h0400, 3, 1);
        vt[12] = mkv(0, 0, 0,      0,  1,  0, 60, 16'h0100, 0, 1);
        vt[13] = mkv(0, 0, 0,      0,  1,  0, 60, 16'h0200, 1, 1);
        vt[14] = mkv(0, 0, 0,      0,  1,  0, 60, 16'h0100, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq", 32'(freq), 32'd0);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 4; i++) wr_entry(i, (i + 1) * 'h100, 1'b1);
        @(negedge clk); length = 3'd3; run = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven steps: plain loop, rest step, retrigger, length shrink.
        for (int i = 0; i < 15; i++) begin
            if (vt[i].do_wr) wr_entry(vt[i].wa, vt[i].wf, vt[i].wact);
            @(negedge clk); length = vt[i].len; tick = 1'b1;
            repeat (3) @(posedge clk);
            #1 chk("vec_preload_strobe", 32'(step_strobe), 32'd0);
            @(negedge clk); tick = 1'b0;
            @(posedge clk); #1;
            if (vt[i].retrig) begin
                chk("vec_retrig_gate_low", 32'(gate), 32'd0);
                chk("vec_retrig_strobe", 32'(step_strobe), 32'd0);
                @(posedge clk); #1;
            end
            chk("vec_strobe", 32'(step_strobe), 32'd1);
            chk("vec_freq", 32'(freq), 32'(vt[i].efreq));
            chk("vec_step", 32'(step), 32'(vt[i].estep));
            chk("vec_gate", 32'(gate), 32'(vt[i].egate));
            repeat (vt[i].gap) @(negedge clk);
        end

        // Gate width of an uninterrupted note (plays step 1).
        @(negedge clk); length = 3'd3;
        do_step("width");
        cnt_hi = 0;
        while (gate && cnt_hi < 200) begin
            cnt_hi++;
            @(posedge clk); #1;
        end
        chk("gate_width", 32'(cnt_hi), 32'(GC));
        repeat (30) @(negedge clk);

        // Write entry 2 on the very edge it loads: old value out now, new value next lap.
        @(negedge clk); tick = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_freq = 16'h0BEE; wr_active = 1'b1;
        @(posedge clk); #1;
        chk("rbw_strobe", 32'(step_strobe), 32'd1);
        chk("rbw_old_freq", 32'(freq), 32'h0300);
        chk("rbw_step", 32'(step), 32'd2);
        @(negedge clk); wr_en = 1'b0;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_step("lap");
            repeat (60) @(negedge clk);
        end
        do_step("rbw_lap");
        chk("rbw_new_freq", 32'(freq), 32'h0BEE);
        chk("rbw_lap_step", 32'(step), 32'd2);
        repeat (60) @(negedge clk);

        // Drop run mid-note, tick while stopped, then restart from step 0.
        do_step("run_note");
        repeat (5) @(negedge clk);
        run = 1'b0;
        @(posedge clk); #1;
        chk("run_drop_gate", 32'(gate), 32'd0);
        @(negedge clk); tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (step_strobe) strobes++;
        end
        chk("run_low_ignored", 32'(strobes), 32'd0);
        @(negedge clk); run = 1'b1;
        do_step("restart");
        chk("restart_step", 32'(step), 32'd0);
        chk("restart_freq", 32'(freq), 32'h0100);

        // Asynchronous reset in the middle of a note.
        repeat (5) @(negedge clk);
        do_step("rst_note");
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("async_rst_freq", 32'(freq), 32'd0);
        chk("async_rst_gate", 32'(gate), 32'd0);
        chk("async_rst_step", 32'(step), 32'd0);
        chk("async_rst_strobe", 32'(step_strobe), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_step("post_rst");
        chk("post_rst_freq", 32'(freq), 32'd0);
        chk("post_rst_gate", 32'(gate), 32'd1);
        repeat (60) @(negedge clk);

        // Randomized traffic; the per-cycle model checks everything.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); length = AW'($urandom_range(0, STEPS - 1));
            end
            if ($urandom_range(0, 3) == 0)
                wr_entry(int'($urandom_range(0, STEPS - 1)), int'($urandom_range(0, 16'hFFFF)),
                         1'($urandom_range(0, 1)));
            @(negedge clk);
            run  = ($urandom_range(0, 11) != 0);
            tick = 1'b1;
            repeat ($urandom_range(2, 4)) @(negedge clk);
            tick = 1'b0;
            repeat ($urandom_range(1, 55)) @(negedge clk);
        end
        @(negedge clk); run = 1'b1;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
